// File: rtl/alu_pkg.sv
// Shared types for the ALU sharing logic: opcode encoding and arbiter FSM states.
package alu_pkg;

    typedef logic [3:0] opcode_t;

    localparam opcode_t OP_LAST_VALID = 4'h3;
    localparam opcode_t OP_HALT       = 4'hF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    // Opcodes above OP_LAST_VALID never reach the datapath; HALT is the common case.
    function automatic logic op_is_valid(input opcode_t op);
        logic ok_s;
        if (op == OP_HALT) begin
            ok_s = 1'b0;
        end else begin
            ok_s = (op <= OP_LAST_VALID);
        end
        return ok_s;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request searching upward from last+1, wrapping.
module rr_pick #(
    parameter int N     = 2,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] last,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    // Priority scan starting just after the previously served requester
    always_comb begin
        int pos_s;
        pos_s = 0;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        for (int i = 1; i <= N; i++) begin
            pos_s = (int'(last) + i) % N;
            if (!any && req[pos_s]) begin
                any          = 1'b1;
                grant[pos_s] = 1'b1;
                idx          = IDX_W'(pos_s);
            end else begin
                any = any;
            end
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin owner of the shared ALU datapath: captures one request, runs it to done or
// timeout, then returns the result with a one-cycle ack to the granted controller.
module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int WIDTH   = 16,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 32
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ-1:0][3:0]       req_opcode,
    input  logic [NUM_REQ-1:0][DATA_W-1:0] req_a,
    input  logic [NUM_REQ-1:0][DATA_W-1:0] req_b,
    output logic [NUM_REQ-1:0]            grant,
    output logic [NUM_REQ-1:0]            ack,
    output logic [WIDTH-1:0]              rsp_result,
    output logic                          rsp_err,
    output logic                          busy,
    output logic                          enable,
    output logic [3:0]                    opcode,
    output logic [DATA_W-1:0]             a,
    output logic [DATA_W-1:0]             b,
    input  logic [WIDTH-1:0]              dp_result,
    input  logic                          done
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    arb_state_t          state_r, state_s;
    logic [NUM_REQ-1:0]  grant_r, grant_s, ack_r, ack_s;
    logic [WIDTH-1:0]    result_r, result_s;
    logic                err_r, err_s, busy_r, busy_s, enable_r, enable_s;
    opcode_t             opcode_r, opcode_s;
    logic [DATA_W-1:0]   a_r, a_s, b_r, b_s;
    logic [IDX_W-1:0]    idx_r, idx_s, last_r, last_s;
    logic [CNT_W-1:0]    cnt_r, cnt_s;

    logic [NUM_REQ-1:0]  pick_grant_s;
    logic [IDX_W-1:0]    pick_idx_s;
    logic                pick_any_s;

    rr_pick #(.N(NUM_REQ), .IDX_W(IDX_W)) u_pick (
        .req   (req),
        .last  (last_r),
        .grant (pick_grant_s),
        .idx   (pick_idx_s),
        .any   (pick_any_s)
    );

    // Next-state and next-output computation; every output is registered below
    always_comb begin
        state_s  = state_r;
        grant_s  = grant_r;
        ack_s    = '0;
        result_s = result_r;
        err_s    = err_r;
        enable_s = enable_r;
        opcode_s = opcode_r;
        a_s      = a_r;
        b_s      = b_r;
        idx_s    = idx_r;
        last_s   = last_r;
        cnt_s    = cnt_r;
        case (state_r)
            IDLE: begin
                if (pick_any_s) begin
                    grant_s = pick_grant_s;
                    idx_s   = pick_idx_s;
                    if (op_is_valid(req_opcode[pick_idx_s])) begin
                        state_s  = EXEC;
                        enable_s = 1'b1;
                        opcode_s = req_opcode[pick_idx_s];
                        a_s      = req_a[pick_idx_s];
                        b_s      = req_b[pick_idx_s];
                    end else begin
                        // Rejected without ever touching the datapath
                        state_s  = RESP;
                        ack_s    = pick_grant_s;
                        err_s    = 1'b1;
                        result_s = '0;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            EXEC: begin
                cnt_s = cnt_r + CNT_W'(1);
                if (done || (cnt_r == CNT_W'(TIMEOUT - 1))) begin
                    state_s  = RESP;
                    ack_s    = grant_r;
                    enable_s = 1'b0;
                    opcode_s = 4'h0;
                    a_s      = '0;
                    b_s      = '0;
                    // done takes precedence over a coincident timeout
                    result_s = done ? dp_result : '0;
                    err_s    = ~done;
                end else begin
                    state_s = EXEC;
                end
            end
            RESP: begin
                state_s  = IDLE;
                grant_s  = '0;
                last_s   = idx_r;
                cnt_s    = '0;
                result_s = '0;
                err_s    = 1'b0;
            end
            default: begin
                state_s  = IDLE;
                grant_s  = '0;
                enable_s = 1'b0;
                cnt_s    = '0;
            end
        endcase
        busy_s = (state_s != IDLE);
    end

    // State and output registers; reset abandons any operation without an ack
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r  <= IDLE;
            grant_r  <= '0;
            ack_r    <= '0;
            result_r <= '0;
            err_r    <= 1'b0;
            busy_r   <= 1'b0;
            enable_r <= 1'b0;
            opcode_r <= 4'h0;
            a_r      <= '0;
            b_r      <= '0;
            idx_r    <= '0;
            last_r   <= IDX_W'(NUM_REQ - 1);
            cnt_r    <= '0;
        end else begin
            state_r  <= state_s;
            grant_r  <= grant_s;
            ack_r    <= ack_s;
            result_r <= result_s;
            err_r    <= err_s;
            busy_r   <= busy_s;
            enable_r <= enable_s;
            opcode_r <= opcode_s;
            a_r      <= a_s;
            b_r      <= b_s;
            idx_r    <= idx_s;
            last_r   <= last_s;
            cnt_r    <= cnt_s;
        end
    end

    assign grant      = grant_r;
    assign ack        = ack_r;
    assign rsp_result = result_r;
    assign rsp_err    = err_r;
    assign busy       = busy_r;
    assign enable     = enable_r;
    assign opcode     = opcode_r;
    assign a          = a_r;
    assign b          = b_r;

endmodule
